// File: rtl/jk_cmd_sequencer.sv
// Queues 2-bit JK commands, issues them onto J/K one per cycle, and checks the
// returned Q against a behavioural expectation, halting on the first divergence.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_code,
    output logic             cmd_ready,
    output logic             J,
    output logic             K,
    input  logic             Q,
    input  logic             clear_err,
    output logic             busy,
    output logic             mismatch,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [1:0]       o_dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_j;
    logic             r_k;
    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mismatch;
    logic             r_track_valid;
    logic             r_exp_q;
    logic             r_s1_valid;
    logic             r_s1_exp;
    logic             r_s2_valid;
    logic             r_s2_exp;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head;
    logic             w_exp_nxt;
    logic             w_tv_nxt;
    logic             w_cmp_fail;

    // Handshake: a command transfers at a rising edge when cmd_valid and
    // cmd_ready are both 1; cmd_ready is derived only from registered FIFO state.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign cmd_ready = !w_full;

    // Expected Q after the head command takes effect on the downstream flip-flop.
    always_comb begin
        w_exp_nxt = r_exp_q;
        w_tv_nxt  = r_track_valid;
        case (w_head)
            2'b10: begin w_exp_nxt = 1'b1;     w_tv_nxt = 1'b1; end
            2'b01: begin w_exp_nxt = 1'b0;     w_tv_nxt = 1'b1; end
            2'b11: begin w_exp_nxt = ~r_exp_q; end
            default: begin w_exp_nxt = r_exp_q; end
        endcase
    end

    assign w_cmp_fail = r_s2_valid && (Q != r_s2_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (w_cmp_fail) begin
            w_state_nxt = S_HALT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_HALT: begin
                    if (clear_err) begin
                        w_state_nxt = w_empty ? S_IDLE : S_RUN;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= cmd_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_j      <= 1'b0;
            r_k      <= 1'b0;
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_j      <= w_pop ? w_head[1] : 1'b0;
            r_k      <= w_pop ? w_head[0] : 1'b0;
            r_active <= w_pop;
            if (w_pop) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Two-stage delay: J/K driven after edge E, captured downstream at E+1, checked at E+2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_track_valid <= 1'b0;
            r_exp_q       <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_exp      <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s2_exp      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_track_valid <= w_tv_nxt;
                r_exp_q       <= w_exp_nxt;
            end
            r_s1_valid <= w_pop && w_tv_nxt;
            r_s1_exp   <= w_exp_nxt;
            r_s2_valid <= r_s1_valid;
            r_s2_exp   <= r_s1_exp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mismatch <= 1'b0;
        end else if (w_cmp_fail) begin
            r_mismatch <= 1'b1;
        end else if (clear_err) begin
            r_mismatch <= 1'b0;
        end
    end

    assign J           = r_j;
    assign K           = r_k;
    assign busy        = !w_empty || ((r_state == S_RUN) && r_active);
    assign mismatch    = r_mismatch;
    assign issued_cnt  = r_cnt;
    assign o_dbg_state = r_state;

endmodule
